// File: rtl/regfile_sb.sv
// regfile_sb: register file with two write ports, registered dual read
// ports, optional write forwarding and a pending-load scoreboard.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   r_addr_a, r_addr_b    read addresses, sampled every rising edge
//   r_data_a, r_data_b    registered read data
//   busy_a, busy_b        registered scoreboard bits for the read addresses
//   we0/w_addr0/w_data0   write port 0 (ALU writeback)
//   we1/w_addr1/w_data1   write port 1 (load writeback; also retires busy)
//   busy_set, busy_addr   mark a register as awaiting a load
module regfile_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] r_addr_a,
    input  logic [ADDR_W-1:0] r_addr_b,
    output logic [DATA_W-1:0] r_data_a,
    output logic [DATA_W-1:0] r_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              we0,
    input  logic [ADDR_W-1:0] w_addr0,
    input  logic [DATA_W-1:0] w_data0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] w_addr1,
    input  logic [DATA_W-1:0] w_data1,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR = ZERO_REG != 0;
    localparam bit BP = BYPASS != 0;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr0;
    logic              wr1;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // Writes to a hardwired zero register are discarded before they can
    // reach either the array or the forwarding path.
    assign wr0 = we0 && !(ZR && w_addr0 == '0);
    assign wr1 = we1 && !(ZR && w_addr1 == '0);

    // Set is applied after clear so a new load issued in the cycle the old
    // one retires keeps the register marked.
    always_comb begin
        busy_nxt = busy;
        if (we1)
            busy_nxt[w_addr1] = 1'b0;
        if (busy_set && !(ZR && busy_addr == '0))
            busy_nxt[busy_addr] = 1'b1;
    end

    // Forwarding mirrors the array's port-1-over-port-0 write priority so the
    // read result always matches the post-edge register contents.
    always_comb begin
        fwd_a = (ZR && r_addr_a == '0)             ? '0 :
                (BP && wr1 && w_addr1 == r_addr_a) ? w_data1 :
                (BP && wr0 && w_addr0 == r_addr_a) ? w_data0 : regs[r_addr_a];
        fwd_b = (ZR && r_addr_b == '0)             ? '0 :
                (BP && wr1 && w_addr1 == r_addr_b) ? w_data1 :
                (BP && wr0 && w_addr0 == r_addr_b) ? w_data0 : regs[r_addr_b];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy     <= '0;
            r_data_a <= '0;
            r_data_b <= '0;
            busy_a   <= 1'b0;
            busy_b   <= 1'b0;
        end else begin
            if (wr0)
                regs[w_addr0] <= w_data0;
            if (wr1)
                regs[w_addr1] <= w_data1;
            busy     <= busy_nxt;
            r_data_a <= fwd_a;
            r_data_b <= fwd_b;
            busy_a   <= busy_nxt[r_addr_a];
            busy_b   <= busy_nxt[r_addr_b];
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for two regfile_sb configurations sharing one stimulus stream.
module tb_regfile_sb;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] r_addr_a, r_addr_b, w_addr0, w_addr1, busy_addr;
    logic [7:0] w_data0, w_data1;
    logic       we0, we1, busy_set;
    logic [7:0] rda0, rdb0, rda1, rdb1;
    logic       ba0, bb0, ba1, bb1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] da [2];
        logic [7:0] db [2];
        logic       ba [2];
        logic       bb [2];
    } exp_t;
    exp_t q[$];

    logic [7:0] m_reg  [2][8];
    logic       m_busy [2][8];

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk(clk), .reset(reset), .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
        .r_data_a(rda0), .r_data_b(rdb0), .busy_a(ba0), .busy_b(bb0),
        .we0(we0), .w_addr0(w_addr0), .w_data0(w_data0),
        .we1(we1), .w_addr1(w_addr1), .w_data1(w_data1),
        .busy_set(busy_set), .busy_addr(busy_addr)
    );

    regfile_sb #(.ZERO_REG(1), .BYPASS(0)) u_alt (
        .clk(clk), .reset(reset), .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
        .r_data_a(rda1), .r_data_b(rdb1), .busy_a(ba1), .busy_b(bb1),
        .we0(we0), .w_addr0(w_addr0), .w_data0(w_data0),
        .we1(we1), .w_addr1(w_addr1), .w_data1(w_data1),
        .busy_set(busy_set), .busy_addr(busy_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instance 0: ZERO_REG=0 BYPASS=1; instance 1: ZERO_REG=1 BYPASS=0.
    task automatic cyc();
        exp_t e;
        logic [7:0] nr [8];
        logic       nb [8];
        bit zr, bp;
        for (int k = 0; k < 2; k++) begin
            zr = (k == 1);
            bp = (k == 0);
            for (int i = 0; i < 8; i++) begin
                nr[i] = m_reg[k][i];
                nb[i] = m_busy[k][i];
            end
            if (we0 && !(zr && w_addr0 == 0)) nr[w_addr0] = w_data0;
            if (we1 && !(zr && w_addr1 == 0)) nr[w_addr1] = w_data1;
            if (we1) nb[w_addr1] = 1'b0;
            if (busy_set && !(zr && busy_addr == 0)) nb[busy_addr] = 1'b1;
            if (reset) begin
                for (int i = 0; i < 8; i++) begin
                    nr[i] = 8'h00;
                    nb[i] = 1'b0;
                end
                e.da[k] = 8'h00;
                e.db[k] = 8'h00;
            end else begin
                e.da[k] = (zr && r_addr_a == 0) ? 8'h00 : bp ? nr[r_addr_a] : m_reg[k][r_addr_a];
                e.db[k] = (zr && r_addr_b == 0) ? 8'h00 : bp ? nr[r_addr_b] : m_reg[k][r_addr_b];
            end
            e.ba[k] = reset ? 1'b0 : nb[r_addr_a];
            e.bb[k] = reset ? 1'b0 : nb[r_addr_b];
            for (int i = 0; i < 8; i++) begin
                m_reg[k][i]  = nr[i];
                m_busy[k][i] = nb[i];
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        chk("queue_nonempty", q.size(), q.size() == 0 ? 1 : q.size());
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL queue_empty: got 0 expected 1");
        end else begin
            e = q.pop_front();
            chk("r_data_a[0]", rda0, e.da[0]);
            chk("r_data_b[0]", rdb0, e.db[0]);
            chk("busy_a[0]",   ba0,  e.ba[0]);
            chk("busy_b[0]",   bb0,  e.bb[0]);
            chk("r_data_a[1]", rda1, e.da[1]);
            chk("r_data_b[1]", rdb1, e.db[1]);
            chk("busy_a[1]",   ba1,  e.ba[1]);
            chk("busy_b[1]",   bb1,  e.bb[1]);
        end
    endtask

    task automatic drive(input logic rst,
                         input logic e0, input logic [2:0] a0, input logic [7:0] d0,
                         input logic e1, input logic [2:0] a1, input logic [7:0] d1,
                         input logic bs, input logic [2:0] bad,
                         input logic [2:0] ra, input logic [2:0] rb);
        reset = rst; we0 = e0; w_addr0 = a0; w_data0 = d0;
        we1 = e1; w_addr1 = a1; w_data1 = d1;
        busy_set = bs; busy_addr = bad; r_addr_a = ra; r_addr_b = rb;
        cyc();
    endtask

    task automatic rd(input logic [2:0] ra, input logic [2:0] rb);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) begin
                m_reg[k][i]  = 8'hxx;
                m_busy[k][i] = 1'bx;
            end
        #1;
        // 1: reset then sweep all addresses
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) rd(3'(i), 3'(7 - i));
        // 2: write then read, then same-cycle write/read
        drive(0, 1, 3, 8'h5A, 0, 0, 0, 0, 0, 0, 0);
        rd(3, 3);
        chk("plan_rd3", rda0, 8'h5A);
        drive(0, 1, 3, 8'hC3, 0, 0, 0, 0, 0, 3, 3);
        chk("plan_byp", rda0, 8'hC3);
        chk("plan_nobyp", rda1, 8'h5A);
        rd(3, 3);
        chk("plan_late", rda1, 8'hC3);
        // 3: collision
        drive(0, 1, 5, 8'h11, 1, 5, 8'h22, 0, 0, 5, 5);
        chk("plan_coll_byp", rda0, 8'h22);
        rd(5, 5);
        chk("plan_coll", rdb1, 8'h22);
        // 4: scoreboard on 6
        drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 6, 6);
        chk("plan_busy_set", ba0, 1'b1);
        drive(0, 0, 0, 0, 1, 6, 8'h77, 0, 0, 6, 6);
        chk("plan_busy_clr", ba0, 1'b0);
        drive(0, 0, 0, 0, 1, 6, 8'h88, 1, 6, 6, 6);
        chk("plan_set_wins", ba1, 1'b1);
        drive(0, 1, 6, 8'h99, 0, 0, 0, 0, 0, 6, 6);
        chk("plan_we0_busy", ba0, 1'b1);
        // 5: zero register
        drive(0, 1, 0, 8'hFF, 0, 0, 0, 1, 0, 0, 0);
        rd(0, 0);
        chk("plan_zr0", rda0, 8'hFF);
        chk("plan_zr1", rda1, 8'h00);
        chk("plan_zr1_busy", ba1, 1'b0);
        drive(0, 0, 0, 0, 1, 0, 8'hEE, 1, 0, 0, 0);
        // 6: load registers, set busy, reset with writes active
        for (int i = 0; i < 8; i++)
            drive(0, 1, 3'(i), 8'(8'h11 * (i + 1)), 0, 0, 0, 1, 3'(i), 3'(i), 3'(7 - i));
        drive(1, 1, 2, 8'hAB, 1, 4, 8'hCD, 1, 5, 2, 4);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 3'(i));
            chk("plan_rst_data", rda0, 8'h00);
        end
        // random traffic
        for (int n = 0; n < 200; n++)
            drive(($urandom_range(0, 39) == 0),
                  1'($urandom), 3'($urandom), 8'($urandom),
                  1'($urandom), 3'($urandom), 8'($urandom),
                  1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
